// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - MEM-stage, DMA and data-memory bus bundle for dmem_arbiter
interface dmem_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_ack;

    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport master (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport slave (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory arbiter between MEM stage and DMA; DMA port present only with DMEM_ARB_DMA_EN
module dmem_arbiter #(
    parameter int RAM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  wait_cnt, wait_cnt_nxt;
    logic        owner_dma;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] mem_rdata_q;
    logic [31:0] dma_rdata_q;
    logic        grant_dma;
    logic        any_req;

`ifdef DMEM_ARB_DMA_EN
    logic [2:0] starve_cnt;

    // MEM keeps priority until DMA has lost STARVE_MAX conflicts in a row
    assign grant_dma = bus.dma_req & (~bus.mem_req | (starve_cnt == 3'(STARVE_MAX)));

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 3'd0;
        end else if (state == IDLE) begin
            if (grant_dma)
                starve_cnt <= 3'd0;
            else if (bus.mem_req && bus.dma_req && starve_cnt != 3'd7)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

    assign bus.dma_ack   = (state == DONE) && owner_dma;
    assign bus.dma_rdata = bus.dma_ack ? bus.ram_rdata : dma_rdata_q;
`else
    logic unused_dma;

    assign grant_dma     = 1'b0;
    assign bus.dma_ack   = 1'b0;
    assign bus.dma_rdata = 32'd0;
    assign unused_dma    = ^{bus.dma_req, bus.dma_we, bus.dma_addr, bus.dma_wdata, dma_rdata_q};
`endif

    assign any_req = bus.mem_req | grant_dma;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 3'd0;
            owner_dma   <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            mem_rdata_q <= 32'd0;
            dma_rdata_q <= 32'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == IDLE && any_req) begin
                owner_dma <= grant_dma;
                lat_we    <= grant_dma ? bus.dma_we    : bus.mem_we;
                lat_addr  <= grant_dma ? bus.dma_addr  : bus.mem_addr;
                lat_wdata <= grant_dma ? bus.dma_wdata : bus.mem_wdata;
            end
            if (state == DONE) begin
                if (owner_dma)
                    dma_rdata_q <= bus.ram_rdata;
                else
                    mem_rdata_q <= bus.ram_rdata;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (RAM_LAT == 1) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = 3'(RAM_LAT - 2);
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0)
                    state_nxt = DONE;
                else
                    wait_cnt_nxt = wait_cnt - 3'd1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ram_en    = (state == ISSUE);
    assign bus.ram_we    = lat_we;
    assign bus.ram_addr  = lat_addr;
    assign bus.ram_wdata = lat_wdata;

    assign bus.mem_rdata = (state == DONE && !owner_dma) ? bus.ram_rdata : mem_rdata_q;
    assign bus.mem_stall = ~reset & bus.mem_req & ~(state == DONE && !owner_dma);
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
    localparam int RAM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if bif ();
    dmem_arbiter_if bif1 ();

    dmem_arbiter #(.RAM_LAT(RAM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset), .bus(bif)
    );
    dmem_arbiter #(.RAM_LAT(1), .STARVE_MAX(STARVE_MAX)) dut1 (
        .clk(clk), .reset(reset), .bus(bif1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] model_mem [64];
    logic [31:0] ram_arr   [64];
    logic [31:0] rd_pipe   [RAM_LAT];

    // Data memory: read data valid exactly RAM_LAT cycles after ram_en, junk otherwise
    assign bif.ram_rdata = rd_pipe[RAM_LAT-1];
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 64; k++) ram_arr[k] <= model_mem[k];
        end else if (bif.ram_en && bif.ram_we) begin
            ram_arr[bif.ram_addr[5:0]] <= bif.ram_wdata;
        end
        rd_pipe[0] <= bif.ram_en ? ram_arr[bif.ram_addr[5:0]] : $urandom;
        for (int k = 1; k < RAM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        bif1.ram_rdata <= bif1.ram_en ? ram_arr[bif1.ram_addr[5:0]] : $urandom;
    end

    task automatic test_reset();
        bif.mem_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bif.mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", bif.mem_stall);
        end
        n_cmp++;
        if ({bif.ram_en, bif.ram_we, bif.dma_ack} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000", {bif.ram_en, bif.ram_we, bif.dma_ack});
        end
        n_cmp++;
        if (bif.ram_addr !== 32'd0 || bif.ram_wdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_ram_bus: got %h/%h want 0/0", bif.ram_addr, bif.ram_wdata);
        end
        n_cmp++;
        if (bif.mem_rdata !== 32'd0 || bif.dma_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", bif.mem_rdata, bif.dma_rdata);
        end
        bif.mem_req = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_mem_access();
        logic        we;
        logic [31:0] addr, wdata, exp, got;
        int          stalls, ens, cyc;
        bit          done;
        for (int t = 0; t < 10; t++) begin
            if (t == 0) begin
                we = 1'b0; addr = 32'h10; wdata = 32'd0;
            end else begin
                we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
            end
            exp = model_mem[addr[5:0]];
            bif.mem_we = we; bif.mem_addr = addr; bif.mem_wdata = wdata; bif.mem_req = 1'b1;
            stalls = 0; ens = 0; cyc = 0; done = 0; got = 32'd0;
            while (!done && cyc < 20) begin
                #1;
                if (bif.ram_en) begin
                    ens++;
                    n_cmp++;
                    if (bif.ram_addr !== addr || bif.ram_we !== we || bif.ram_wdata !== wdata) begin
                        n_fail++;
                        $display("FAIL mem_issue[%0d]: got %h/%b/%h want %h/%b/%h", t,
                                 bif.ram_addr, bif.ram_we, bif.ram_wdata, addr, we, wdata);
                    end
                end
                if (bif.mem_stall) stalls++;
                else begin done = 1; got = bif.mem_rdata; end
                @(posedge clk); #1;
                cyc++;
            end
            bif.mem_req = 1'b0;
            n_cmp++;
            if (!done || stalls != RAM_LAT + 1) begin
                n_fail++; $display("FAIL mem_stall_len[%0d]: got %0d (done=%0d) want %0d", t, stalls, done, RAM_LAT + 1);
            end
            n_cmp++;
            if (ens != 1) begin
                n_fail++; $display("FAIL mem_ram_en_count[%0d]: got %0d want 1", t, ens);
            end
            if (!we) begin
                n_cmp++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL mem_rdata[%0d]: got %h want %h", t, got, exp);
                end
            end
            #1;
            n_cmp++;
            if (bif.mem_rdata !== got) begin
                n_fail++; $display("FAIL mem_rdata_hold[%0d]: got %h want %h", t, bif.mem_rdata, got);
            end
            if (we) model_mem[addr[5:0]] = wdata;
        end
    endtask

    task automatic test_lat1();
        logic [31:0] addr, got;
        int          stalls, cyc;
        bit          done;
        for (int t = 0; t < 3; t++) begin
            addr = $urandom;
            bif1.mem_we = 1'b0; bif1.mem_addr = addr; bif1.mem_req = 1'b1;
            stalls = 0; cyc = 0; done = 0; got = 32'd0;
            while (!done && cyc < 20) begin
                #1;
                if (bif1.mem_stall) stalls++;
                else begin done = 1; got = bif1.mem_rdata; end
                @(posedge clk); #1;
                cyc++;
            end
            bif1.mem_req = 1'b0;
            n_cmp++;
            if (!done || stalls != 2) begin
                n_fail++; $display("FAIL lat1_stall_len[%0d]: got %0d (done=%0d) want 2", t, stalls, done);
            end
            n_cmp++;
            if (got !== model_mem[addr[5:0]]) begin
                n_fail++; $display("FAIL lat1_rdata[%0d]: got %h want %h", t, got, model_mem[addr[5:0]]);
            end
        end
    endtask

`ifdef DMEM_ARB_DMA_EN
    task automatic test_dma_write();
        int en_cyc, ack_cyc, ens, acks;
        bif.dma_we = 1'b1; bif.dma_addr = 32'h20; bif.dma_wdata = 32'h1234; bif.dma_req = 1'b1;
        en_cyc = -1; ack_cyc = -1; ens = 0; acks = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bif.ram_en) begin
                ens++; en_cyc = c;
                n_cmp++;
                if (bif.ram_we !== 1'b1 || bif.ram_addr !== 32'h20 || bif.ram_wdata !== 32'h1234) begin
                    n_fail++;
                    $display("FAIL dma_issue: got %b/%h/%h want 1/00000020/00001234", bif.ram_we, bif.ram_addr, bif.ram_wdata);
                end
            end
            if (bif.dma_ack) begin
                acks++; ack_cyc = c;
                bif.dma_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (ens != 1 || acks != 1) begin
            n_fail++; $display("FAIL dma_pulses: got en=%0d ack=%0d want 1/1", ens, acks);
        end
        n_cmp++;
        if (ack_cyc - en_cyc != RAM_LAT) begin
            n_fail++; $display("FAIL dma_ack_latency: got %0d want %0d", ack_cyc - en_cyc, RAM_LAT);
        end
        model_mem[32] = 32'h1234;
    endtask

    task automatic test_starve();
        logic [31:0] maddr, daddr;
        int          cnt, n_arb;
        bit          exp_dma;
        cnt = 0; n_arb = 0;
        maddr = $urandom & 32'h7FFF_FFFF;
        daddr = $urandom | 32'h8000_0000;
        bif.mem_we = 1'b0; bif.dma_we = 1'b0;
        bif.mem_addr = maddr; bif.dma_addr = daddr;
        bif.mem_req = 1'b1; bif.dma_req = 1'b1;
        for (int c = 0; c < 200 && n_arb < 12; c++) begin
            #1;
            if (bif.ram_en) begin
                exp_dma = (cnt == STARVE_MAX);
                cnt = exp_dma ? 0 : (cnt < 7 ? cnt + 1 : 7);
                n_cmp++;
                if (bif.ram_addr !== (exp_dma ? daddr : maddr)) begin
                    n_fail++;
                    $display("FAIL starve_grant[%0d]: got addr %h want %s %h", n_arb, bif.ram_addr,
                             exp_dma ? "dma" : "mem", exp_dma ? daddr : maddr);
                end
                n_arb++;
            end
            if (bif.dma_ack) begin
                n_cmp++;
                if (bif.dma_rdata !== model_mem[daddr[5:0]]) begin
                    n_fail++; $display("FAIL starve_dma_rdata: got %h want %h", bif.dma_rdata, model_mem[daddr[5:0]]);
                end
                daddr = $urandom | 32'h8000_0000;
                bif.dma_addr = daddr;
            end
            if (!bif.mem_stall) begin
                n_cmp++;
                if (bif.mem_rdata !== model_mem[maddr[5:0]]) begin
                    n_fail++; $display("FAIL starve_mem_rdata: got %h want %h", bif.mem_rdata, model_mem[maddr[5:0]]);
                end
                maddr = $urandom & 32'h7FFF_FFFF;
                bif.mem_addr = maddr;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (n_arb != 12) begin
            n_fail++; $display("FAIL starve_timeout: got %0d grants want 12", n_arb);
        end
        bif.mem_req = 1'b0; bif.dma_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask
`else
    task automatic test_dma_ignored();
        int ens, acks, nz;
        ens = 0; acks = 0; nz = 0;
        bif.dma_we = 1'b1; bif.dma_addr = $urandom; bif.dma_wdata = $urandom; bif.dma_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bif.ram_en) ens++;
            if (bif.dma_ack) acks++;
            if (bif.dma_rdata !== 32'd0) nz++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (ens != 0 || acks != 0) begin
            n_fail++; $display("FAIL dma_disabled: got en=%0d ack=%0d want 0/0", ens, acks);
        end
        n_cmp++;
        if (nz != 0) begin
            n_fail++; $display("FAIL dma_disabled_rdata: got %0d nonzero cycles want 0", nz);
        end
        bif.dma_req = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        int  ens, acks, stalls;
        bit  seen;
        seen = 0;
`ifdef DMEM_ARB_DMA_EN
        bif.dma_we = 1'b0; bif.dma_addr = $urandom; bif.dma_req = 1'b1;
`else
        bif.mem_we = 1'b0; bif.mem_addr = $urandom; bif.mem_req = 1'b1;
`endif
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (bif.ram_en) seen = 1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++; $display("FAIL reset_mid_issue: got no ram_en want 1");
        end
        reset = 1'b1; bif.dma_req = 1'b0; bif.mem_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bif.ram_addr !== 32'd0 || bif.ram_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_cleared: got %h/%b want 0/0", bif.ram_addr, bif.ram_en);
        end
        ens = 0; acks = 0; stalls = 0;
        for (int c = 0; c < 8; c++) begin
            if (bif.ram_en) ens++;
            if (bif.dma_ack) acks++;
            if (bif.mem_stall) stalls++;
            @(posedge clk); #2;
        end
        n_cmp++;
        if (ens != 0 || acks != 0 || stalls != 0) begin
            n_fail++; $display("FAIL reset_mid_abandon: got en=%0d ack=%0d stall=%0d want 0/0/0", ens, acks, stalls);
        end
    endtask

    initial begin
        reset = 1'b1;
        bif.mem_req = 1'b0; bif.mem_we = 1'b0; bif.mem_addr = 32'd0; bif.mem_wdata = 32'd0;
        bif.dma_req = 1'b0; bif.dma_we = 1'b0; bif.dma_addr = 32'd0; bif.dma_wdata = 32'd0;
        bif1.mem_req = 1'b0; bif1.mem_we = 1'b0; bif1.mem_addr = 32'd0; bif1.mem_wdata = 32'd0;
        bif1.dma_req = 1'b0; bif1.dma_we = 1'b0; bif1.dma_addr = 32'd0; bif1.dma_wdata = 32'd0;
        for (int k = 0; k < 64; k++) model_mem[k] = $urandom;
        model_mem[16] = 32'hDEADBEEF;
        @(posedge clk); #1;
        test_reset();
        test_mem_access();
        test_lat1();
`ifdef DMEM_ARB_DMA_EN
        test_dma_write();
        test_starve();
`else
        test_dma_ignored();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter RAM_LAT, default 2: cycles from ram_en to valid ram_rdata; legal range 1..7.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive DMA losses before DMA gets priority; legal range 1..7.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mem_req, input, 1 bit: MEM stage access request (MemRead|MemWrite); mem_we, input, 1 bit: MEM write.
REQ-006 SHALL have MEM stage data ports: mem_addr, input, 32 bits; mem_wdata, input, 32 bits; mem_rdata, output, 32 bits.
REQ-007 SHALL have port mem_stall, output, 1 bit: hold the pipeline while a MEM access is pending.
REQ-008 SHALL have DMA request ports: dma_req, input, 1 bit; dma_we, input, 1 bit; dma_addr, input, 32 bits; dma_wdata, input, 32 bits.
REQ-009 SHALL have DMA response ports: dma_rdata, output, 32 bits; dma_ack, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have data-memory control outputs: ram_en, 1 bit; ram_we, 1 bit; ram_addr, 32 bits; ram_wdata, 32 bits.
REQ-011 SHALL have port ram_rdata, input, 32 bits: read data from the data memory.

Function
REQ-012 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-013 IDLE: if any request is present, SHALL latch the winner's owner, we, addr and wdata into registers and go to ISSUE; otherwise stay in IDLE.
REQ-014 Arbitration: MEM SHALL win all conflicts unless starve_cnt == STARVE_MAX, in which case DMA wins.
REQ-015 starve_cnt (3 bits) SHALL increment, saturating, when DMA loses a conflict, and SHALL clear when DMA is granted.
REQ-016 ISSUE SHALL assert ram_en=1 for exactly one cycle, with ram_we, ram_addr and ram_wdata driven from the latched registers.
REQ-017 After ISSUE, the FSM SHALL go to WAIT for RAM_LAT-1 cycles, or directly to DONE when RAM_LAT=1.
REQ-018 ram_addr, ram_we and ram_wdata SHALL hold their latched values until the next ISSUE; ram_en SHALL be 0 outside ISSUE.
REQ-019 DONE (one cycle, then IDLE): for owner MEM, mem_rdata = ram_rdata combinationally, and the value SHALL be registered and held afterwards.
REQ-020 DONE for owner DMA: dma_ack = 1 and dma_rdata = ram_rdata, with the same registered hold afterwards.
REQ-021 Writes SHALL follow the identical sequence; read data on write transactions SHALL be don't-care but still registered.
REQ-022 mem_stall SHALL equal mem_req AND NOT (state == DONE AND owner == MEM); an uncontended MEM access therefore stalls 1+RAM_LAT cycles.
REQ-023 A transaction, once latched, SHALL complete even if its request drops; requesters SHALL hold req until completion.
REQ-024 Addresses SHALL pass through unmodified, with no alignment check.

Reset
REQ-025 With reset=1 at a clock edge, the block SHALL enter IDLE and clear starve_cnt, the latched registers, ram_* outputs, mem_rdata and dma_rdata to 0, and dma_ack to 0.
REQ-026 mem_stall SHALL be forced to 0 while reset=1.
REQ-027 Reset mid-transaction SHALL abandon the access: no ack, no further ram_en.

Configuration
REQ-028 Macro DMEM_ARB_DMA_EN defined: the DMA port and starvation logic SHALL be present as above.
REQ-029 Macro DMEM_ARB_DMA_EN undefined: dma_* inputs SHALL be ignored, dma_ack and dma_rdata tied to 0, starve_cnt removed, and MEM the only requester.

Verification (RAM_LAT=2, STARVE_MAX=4, DMEM_ARB_DMA_EN defined)
REQ-030 MEM read, addr 0x10, ram returns 0xDEADBEEF -> mem_stall high 3 cycles, low in DONE with mem_rdata=0xDEADBEEF.
REQ-031 DMA write, addr 0x20, data 0x1234 -> ram_en and ram_we high one cycle with ram_addr=0x20 and ram_wdata=0x1234; dma_ack pulses 2 cycles later.
REQ-032 Simultaneous mem_req and dma_req held continuously -> MEM granted 4 times, then DMA granted on the 5th arbitration, starve_cnt back to 0.
REQ-033 RAM_LAT=1 build, MEM read -> no WAIT state, mem_stall high 2 cycles.
REQ-034 Reset asserted in WAIT of a DMA read -> next cycle IDLE, dma_ack never asserted, ram_en stays 0.
REQ-035 DMEM_ARB_DMA_EN undefined, dma_req held at 1 -> no ram_en from DMA, dma_ack stays 0.
